// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix-multiply engine.
// Holds the FSM state encoding, default sizes and ROM address arithmetic.
package matmul_pkg;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_OUT, S_DONE} state_t;

    localparam int DEF_N       = 4;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_NUM_MAT = 4;

    // Row-major location of element [row][col] in matrix sel of an n x n ROM bank.
    function automatic int addr_of(input int sel, input int row, input int col, input int n);
        return sel * n * n + row * n + col;
    endfunction

endpackage

// File: rtl/matmul_engine_mac.sv
// Single multiply-accumulate lane: registers acc = first ? a*b : acc + a*b,
// with a sticky per-element overflow flag in the selected signedness.
module mac_unit #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              first,
    input  logic              signed_mode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc,
    output logic              ovf
);

    logic signed [2*DATA_W-1:0] prod_s;
    logic        [2*DATA_W-1:0] prod_u;
    logic        [ACC_W-1:0]    prod;
    logic        [ACC_W-1:0]    sum;
    logic                       carry;
    logic                       ovf_add;

    assign prod_s = $signed(a) * $signed(b);
    assign prod_u = a * b;
    // Size casts sign-extend the signed product and zero-extend the unsigned one.
    assign prod   = signed_mode ? ACC_W'(prod_s) : ACC_W'(prod_u);

    assign {carry, sum} = {1'b0, acc} + {1'b0, prod};
    assign ovf_add = signed_mode
                   ? ((acc[ACC_W-1] == prod[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]))
                   : carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            acc <= first ? prod : sum;
            ovf <= first ? 1'b0 : (ovf | ovf_add);
        end
    end

endmodule

// File: rtl/matmul_engine.sv
// N x N matrix multiply over a dual-port synchronous ROM with one MAC,
// streaming C row-major over a valid/ready handshake.
module matmul_engine
    import matmul_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ACC_W   = 2 * DATA_W + $clog2(N),
    parameter int NUM_MAT = DEF_NUM_MAT,
    parameter int SEL_W   = (NUM_MAT > 1) ? $clog2(NUM_MAT) : 1,
    parameter int ADDR_W  = $clog2(NUM_MAT * N * N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [SEL_W-1:0]     sel_a,
    input  logic [SEL_W-1:0]     sel_b,
    input  logic                 signed_mode,
    output logic                 rom_en,
    output logic [ADDR_W-1:0]    rom_addr_a,
    output logic [ADDR_W-1:0]    rom_addr_b,
    input  logic [DATA_W-1:0]    rom_data_a,
    input  logic [DATA_W-1:0]    rom_data_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ACC_W-1:0]     res_data,
    output logic [$clog2(N)-1:0] res_row,
    output logic [$clog2(N)-1:0] res_col,
    output logic                 res_last,
    output logic                 res_ovf,
    output logic                 busy,
    output logic                 done
);

    localparam int IDX_W = $clog2(N);

    state_t             state, state_nx;
    logic [IDX_W-1:0]   i, j, k;
    logic [SEL_W-1:0]   sel_a_q, sel_b_q;
    logic               sgn_q;
    logic               rd_vld, rd_first;
    logic               fetch, last_k, last_el, hs;
    logic [ACC_W-1:0]   acc;
    logic               ovf;

    function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] s);
        return (int'(s) >= NUM_MAT) ? SEL_W'(NUM_MAT - 1) : s;
    endfunction

    assign fetch   = (state == S_FETCH);
    assign last_k  = (k == IDX_W'(N - 1));
    assign last_el = (i == IDX_W'(N - 1)) && (j == IDX_W'(N - 1));
    assign hs      = (state == S_OUT) && res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_FETCH;
            S_FETCH: if (last_k) state_nx = S_DRAIN;
            S_DRAIN: state_nx = S_OUT;
            S_OUT:   if (res_ready) state_nx = last_el ? S_DONE : S_FETCH;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (abort && state != S_IDLE) state_nx = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i        <= '0;
            j        <= '0;
            k        <= '0;
            sel_a_q  <= '0;
            sel_b_q  <= '0;
            sgn_q    <= 1'b0;
            rd_vld   <= 1'b0;
            rd_first <= 1'b0;
        end else begin
            // Tracks the read issued this cycle so its data is consumed next cycle.
            rd_vld   <= fetch && !abort;
            rd_first <= fetch && (k == '0) && !abort;
            if (state == S_IDLE && start) begin
                sel_a_q <= clamp_sel(sel_a);
                sel_b_q <= clamp_sel(sel_b);
                sgn_q   <= signed_mode;
                i       <= '0;
                j       <= '0;
                k       <= '0;
            end else if (fetch) begin
                k <= last_k ? '0 : k + 1'b1;
            end else if (hs && !abort && !last_el) begin
                k <= '0;
                if (j == IDX_W'(N - 1)) begin
                    j <= '0;
                    i <= i + 1'b1;
                end else begin
                    j <= j + 1'b1;
                end
            end
        end
    end

    mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (rd_vld),
        .first       (rd_first),
        .signed_mode (sgn_q),
        .a           (rom_data_a),
        .b           (rom_data_b),
        .acc         (acc),
        .ovf         (ovf)
    );

    assign rom_en     = fetch;
    assign rom_addr_a = fetch ? ADDR_W'(addr_of(int'(sel_a_q), int'(i), int'(k), N)) : '0;
    assign rom_addr_b = fetch ? ADDR_W'(addr_of(int'(sel_b_q), int'(k), int'(j), N)) : '0;

    assign res_valid = (state == S_OUT);
    assign res_data  = res_valid ? acc : '0;
    assign res_row   = res_valid ? i : '0;
    assign res_col   = res_valid ? j : '0;
    assign res_last  = res_valid && last_el;
    assign res_ovf   = res_valid && ovf;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

endmodule

// File: tb/tb_matmul_engine.sv
// Directed bench for matmul_engine at N=2: table of jobs with hand-computed
// products, plus abort, async reset and overflow sequences.
module tb_matmul_engine;
    import matmul_pkg::*;

    localparam int N   = 2;
    localparam int DW  = 8;
    localparam int AW  = 17;
    localparam int NM  = 4;
    localparam int SW  = 2;
    localparam int ADW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          start = 1'b0, abort = 1'b0, signed_mode = 1'b0, res_ready = 1'b0;
    logic [SW-1:0] sel_a = '0, sel_b = '0;
    logic          rom_en, res_valid, res_last, res_ovf, busy, done;
    logic [ADW-1:0] rom_addr_a, rom_addr_b;
    logic [DW-1:0] rom_data_a, rom_data_b;
    logic [AW-1:0] res_data;
    logic [0:0]    res_row, res_col;

    logic          start_o = 1'b0, abort_o = 1'b0, sgn_o = 1'b0, ready_o = 1'b1;
    logic [SW-1:0] sel_o = 2'd3;
    logic          rom_en_o, valid_o, last_o, ovf_o, busy_o, done_o;
    logic [ADW-1:0] addr_ao, addr_bo;
    logic [DW-1:0] data_ao, data_bo;
    logic [15:0]   res_data_o;
    logic [0:0]    row_o, col_o;

    logic [DW-1:0] rom [NM*N*N];

    always @(posedge clk) if (rom_en) begin
        rom_data_a <= rom[rom_addr_a];
        rom_data_b <= rom[rom_addr_b];
    end
    always @(posedge clk) if (rom_en_o) begin
        data_ao <= rom[addr_ao];
        data_bo <= rom[addr_bo];
    end

    matmul_engine #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .sel_a(sel_a), .sel_b(sel_b), .signed_mode(signed_mode),
        .rom_en(rom_en), .rom_addr_a(rom_addr_a), .rom_addr_b(rom_addr_b),
        .rom_data_a(rom_data_a), .rom_data_b(rom_data_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_row(res_row), .res_col(res_col), .res_last(res_last), .res_ovf(res_ovf),
        .busy(busy), .done(done)
    );

    matmul_engine #(.N(N), .ACC_W(16)) dut_o (
        .clk(clk), .rst_n(rst_n), .start(start_o), .abort(abort_o),
        .sel_a(sel_o), .sel_b(sel_o), .signed_mode(sgn_o),
        .rom_en(rom_en_o), .rom_addr_a(addr_ao), .rom_addr_b(addr_bo),
        .rom_data_a(data_ao), .rom_data_b(data_bo),
        .res_valid(valid_o), .res_ready(ready_o), .res_data(res_data_o),
        .res_row(row_o), .res_col(col_o), .res_last(last_o), .res_ovf(ovf_o),
        .busy(busy_o), .done(done_o)
    );

    typedef struct packed {
        logic [1:0]           sa;
        logic [1:0]           sb;
        logic                 sg;
        logic [2:0]           rmode;  // 0 ready=1, 1 backpressure, 2 random, 3 stray starts
        logic [0:3][AW-1:0]   exp;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t vecs[7];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] sa, input logic [1:0] sb, input logic sg,
                                input logic [2:0] rm, input logic [AW-1:0] e0,
                                input logic [AW-1:0] e1, input logic [AW-1:0] e2,
                                input logic [AW-1:0] e3);
        vec_t v;
        v.sa = sa; v.sb = sb; v.sg = sg; v.rmode = rm;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
        return v;
    endfunction

    task automatic load(input int sel, input logic [7:0] e0, input logic [7:0] e1,
                        input logic [7:0] e2, input logic [7:0] e3);
        rom[sel*4+0] = e0; rom[sel*4+1] = e1; rom[sel*4+2] = e2; rom[sel*4+3] = e3;
    endtask

    task automatic run_job(input vec_t v, input logic ab);
        int cyc, n, lat1, latd, hold, bad_bp;
        logic rdy;
        logic [AW-1:0] snap_d;
        logic [0:0] snap_r, snap_c;
        sel_a = v.sa; sel_b = v.sb; signed_mode = v.sg; start = 1'b1; abort = ab;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        cyc = 0; n = 0; lat1 = -1; latd = -1; hold = 0; bad_bp = 0;
        snap_d = '0; snap_r = '0; snap_c = '0;
        while (latd < 0 && cyc < 300) begin
            rdy = 1'b1;
            if (v.rmode == 3'd2) rdy = 1'($urandom_range(0, 1));
            if (v.rmode == 3'd1 && n == 1 && res_valid && hold < 10) begin
                if (hold == 0) begin
                    snap_d = res_data; snap_r = res_row; snap_c = res_col;
                end
                if (res_data !== snap_d || res_row !== snap_r || res_col !== snap_c
                    || rom_en !== 1'b0 || res_valid !== 1'b1) bad_bp++;
                rdy = 1'b0;
                hold++;
            end
            if (v.rmode == 3'd3) begin
                start = (cyc == 1 || cyc == 3);
                if (start) begin sel_a = 2'd3; sel_b = 2'd3; signed_mode = ~v.sg; end
            end
            res_ready = rdy;
            if (res_valid && lat1 < 0) lat1 = cyc + 1;
            if (done) latd = cyc + 1;
            if (res_valid && rdy) begin
                if (n < 4) begin
                    check("data", 64'(res_data), 64'(v.exp[n]));
                    check("row", 64'(res_row), 64'(n / 2));
                    check("col", 64'(res_col), 64'(n % 2));
                    check("last", 64'(res_last), 64'(n == 3));
                    check("ovf", 64'(res_ovf), 64'd0);
                end
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("result_count", 64'(n), 64'd4);
        check("done_seen", 64'(latd > 0), 64'd1);
        if (v.rmode == 3'd0 || v.rmode == 3'd3) begin
            check("first_valid_latency", 64'(lat1), 64'd4);
            check("done_latency", 64'(latd), 64'd17);
        end
        if (v.rmode == 3'd1) begin
            check("bp_hold_cycles", 64'(hold), 64'd10);
            check("bp_stable", 64'(bad_bp), 64'd0);
        end
        check("done_one_cycle", 64'({done, busy}), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual timeout required completion");
        $fatal(1);
    end

    initial begin
        int dn, cnt, n;
        load(0, 8'd1, 8'd2, 8'd3, 8'd4);
        load(1, 8'd5, 8'd6, 8'd7, 8'd8);
        load(2, 8'hFF, 8'd2, 8'd3, 8'hFC);
        load(3, 8'd5, 8'hFA, 8'd7, 8'd8);

        vecs[0] = mk(2'd0, 2'd1, 1'b0, 3'd0, 17'd19, 17'd22, 17'd43, 17'd50);
        vecs[1] = mk(2'd2, 2'd3, 1'b1, 3'd0, 17'd9, 17'd22, 17'd131059, 17'd131022);
        vecs[2] = mk(2'd2, 2'd3, 1'b0, 3'd0, 17'd1289, 17'd63766, 17'd1779, 17'd2766);
        vecs[3] = mk(2'd0, 2'd0, 1'b0, 3'd0, 17'd7, 17'd10, 17'd15, 17'd22);
        vecs[4] = mk(2'd1, 2'd0, 1'b1, 3'd1, 17'd23, 17'd34, 17'd31, 17'd46);
        vecs[5] = mk(2'd0, 2'd1, 1'b0, 3'd2, 17'd19, 17'd22, 17'd43, 17'd50);
        vecs[6] = mk(2'd0, 2'd1, 1'b0, 3'd3, 17'd19, 17'd22, 17'd43, 17'd50);

        repeat (2) @(negedge clk);
        check("reset_outputs", 64'({rom_en, rom_addr_a, rom_addr_b, res_valid, res_data,
                                   res_row, res_col, res_last, res_ovf, busy, done}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_in_idle", 64'({busy, rom_en}), 64'd0);

        // First job also drives abort with start: start must win.
        for (int t = 0; t < 7; t++) run_job(vecs[t], t == 0);

        // Abort while fetching C[1][0].
        sel_a = 2'd0; sel_b = 2'd1; signed_mode = 1'b0; res_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_pre_fetch", 64'({busy, rom_en, res_valid}), 64'b110);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle_next", 64'({busy, res_valid, rom_en}), 64'd0);
        dn = 0;
        repeat (6) begin
            if (done || busy) dn++;
            @(negedge clk);
        end
        check("abort_no_done", 64'(dn), 64'd0);
        run_job(vecs[0], 1'b0);

        // Async reset while holding a result in S_OUT.
        sel_a = 2'd0; sel_b = 2'd1; res_ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (!res_valid && cnt < 20) begin @(negedge clk); cnt++; end
        check("rst_reached_out", 64'(res_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", 64'({res_valid, busy, rom_en, res_data}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        res_ready = 1'b1;
        dn = 0;
        repeat (5) begin
            @(negedge clk);
            if (res_valid || busy) dn++;
        end
        check("rst_no_partial", 64'(dn), 64'd0);
        load(2, 8'd1, 8'd0, 8'd0, 8'd1);
        run_job(mk(2'd2, 2'd2, 1'b0, 3'd0, 17'd1, 17'd0, 17'd0, 17'd1), 1'b0);

        // 16-bit accumulator, all-255 operands: every element wraps.
        load(3, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        start_o = 1'b1;
        @(negedge clk);
        start_o = 1'b0;
        n = 0; cnt = 0;
        while (!done_o && cnt < 100) begin
            if (valid_o) begin
                check("ovf_data", 64'(res_data_o), 64'd64514);
                check("ovf_flag", 64'(ovf_o), 64'd1);
                n++;
            end
            @(negedge clk);
            cnt++;
        end
        check("ovf_count", 64'(n), 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matmul_engine.md
Name: matmul_engine

Overview:
- Parametrised N×N matrix-multiply engine; successor to the fixed top-level multiply flow.
- Reads A and B from a ROM holding NUM_MAT matrices, row-major, through two synchronous read ports.
- Computes C = A·B with a single multiply-accumulate (MAC) unit.
- Streams C out in row-major order over a valid/ready handshake, for the UART transmitter or a debug sink.

Parameters:
- N, 4: matrix dimension (N ≥ 2).
- DATA_W, 8: element width.
- ACC_W, 2*DATA_W+$clog2(N): accumulator and result width.
- NUM_MAT, 4: matrices stored in ROM.
- SEL_W, max(1,$clog2(NUM_MAT)): matrix-select width.
- ADDR_W, $clog2(NUM_MAT*N*N): ROM address width.

Ports:
- clk  in  1  system clock (100 MHz).
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  start pulse; sampled only in S_IDLE.
- abort  in  1  synchronous abort.
- sel_a  in  SEL_W  A matrix index; latched on start.
- sel_b  in  SEL_W  B matrix index; latched on start.
- signed_mode  in  1  1 = two's-complement operands; latched on start.
- rom_en  out  1  read enable for both ports.
- rom_addr_a  out  ADDR_W  A read address.
- rom_addr_b  out  ADDR_W  B read address.
- rom_data_a  in  DATA_W  A data; valid one cycle after rom_en.
- rom_data_b  in  DATA_W  B data; valid one cycle after rom_en.
- res_valid  out  1  result valid.
- res_ready  in  1  sink ready.
- res_data  out  ACC_W  C[i][j].
- res_row  out  $clog2(N)  i.
- res_col  out  $clog2(N)  j.
- res_last  out  1  marks C[N-1][N-1].
- res_ovf  out  1  accumulator overflow on this element.
- busy  out  1  high outside S_IDLE.
- done  out  1  one-cycle pulse after the last result handshake.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: all outputs 0.
  - State and registers: state=S_IDLE; counters, latched selects and accumulator cleared.
- States:
  - S_IDLE: wait for start.
  - S_FETCH: issue N reads for the current element.
  - S_DRAIN: absorb the final read-data beat.
  - S_OUT: present result, wait for handshake.
  - S_DONE: pulse done.
- Start:
  - start=1 in S_IDLE at edge t latches sel_a, sel_b and signed_mode; i=j=k=0; state S_FETCH at t+1.
  - start in any other state is ignored.
- Addressing:
  - base_X = sel_X*N*N.
  - In S_FETCH: rom_addr_a = base_a + i*N + k; rom_addr_b = base_b + k*N + j; rom_en=1.
  - k increments every cycle. After issuing k=N-1, state goes to S_DRAIN.
- Accumulate:
  - Data for the read issued at cycle c is consumed at c+1.
  - First product: acc = product, no clear cycle needed. Later products: acc += product.
  - Product is DATA_W×DATA_W: signed when signed_mode=1 (sign-extended), zero-extended otherwise.
  - Accumulator wraps modulo 2^ACC_W.
  - res_ovf is sticky per element: set if any addition overflows in the selected signedness. Never set at default ACC_W.
- Output:
  - S_DRAIN adds the last product; state goes to S_OUT next cycle.
  - First res_valid appears N+2 cycles after the start edge.
  - In S_OUT: res_valid=1; res_data, res_row, res_col, res_last and res_ovf are held stable until res_valid && res_ready.
  - res_ready=1 at the same edge S_OUT is entered is accepted in that cycle.
- Advance on handshake:
  - Not last: j++; if j wraps then j=0, i++. k=0; state S_FETCH next cycle; res_valid falls.
  - Last: state S_DONE; done=1 for exactly one cycle; then S_IDLE.
- Per-element latency: N+2 cycles plus backpressure. Full matrix with res_ready tied 1: N²·(N+2)+1 cycles from start to done.
- Abort:
  - abort=1 in any non-idle state returns to S_IDLE at the next edge: res_valid=0, rom_en=0, no done pulse.
  - abort has priority over a coincident handshake.
  - abort in S_IDLE has no effect.
  - abort and start together in S_IDLE: start wins.
- Reset mid-operation: immediate return to S_IDLE with outputs 0. No partial result is emitted afterwards.
- Selects out of range (sel ≥ NUM_MAT) are clamped to NUM_MAT-1.

Decomposition:
- matmul_pkg holds:
  - typedef enum logic [2:0] state_t {S_IDLE, S_FETCH, S_DRAIN, S_OUT, S_DONE}.
  - Default parameter constants.
  - Function addr_of(sel, row, col, n).
- One sub-module: mac_unit (DATA_W, ACC_W).
  - Inputs: clk, rst_n, en, first, signed_mode, a, b.
  - Outputs: acc, ovf.
  - Registers the product-accumulate and ovf tracking.
- The FSM, counters and address generation stay in matmul_engine.

Test Plan:
- N=2, DATA_W=8, res_ready=1. A=[[1,2],[3,4]] at sel 0, B=[[5,6],[7,8]] at sel 1, signed_mode=0.
  - Results, in order: 19, 22, 43, 50. res_last only on 50. done one cycle later. First res_valid 4 cycles after start. Total 17 cycles.
- signed_mode=1, A=[[-1,2],[3,-4]], B=[[5,-6],[7,8]].
  - Results: 9, 22, -13, -50 (two's complement, ACC_W=17).
  - Same bytes with signed_mode=0: 255*5+2*7 = 1289 for C[0][0].
- Backpressure: hold res_ready=0 for 10 cycles on C[0][1].
  - res_valid stays 1; data, row and col stay stable; no ROM reads.
  - Release: accepted in 1 cycle and sequence resumes. Random res_ready matches the golden model.
- start pulses during S_FETCH and S_OUT: ignored, sequence unchanged.
  - abort during C[1][0] S_FETCH: busy=0 next cycle, no done.
  - New start then produces all 4 correct results.
- rst_n=0 asserted asynchronously mid-S_OUT: res_valid=0 and busy=0 before the next edge.
  - After release, start with sel_a=sel_b=2 (identity × M) returns M.
- Overflow: ACC_W overridden to 16, signed_mode=0, A and B all 255, N=2.
  - res_ovf=1 on every element; res_data = (2·65025) mod 65536 = 64514.
